// File: rtl/cai_doorbell_arbiter.sv
// Round-robin owner of the single CAI device: counts pending doorbells per requester,
// issues one device submit at a time and returns a completion (or timeout) to its owner.
module cai_doorbell_arbiter #(
  parameter int NREQ           = 4,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 20000,
  localparam int IDW           = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_doorbell,
  output logic [NREQ-1:0]       req_comp,
  output logic [NREQ-1:0]       req_timeout,
  output logic [NREQ*CNT_W-1:0] req_pending,
  input  logic                  dev_ready,
  output logic                  dev_submit_doorbell,
  output logic [IDW-1:0]        dev_grant_id,
  output logic                  dev_busy,
  input  logic                  dev_comp_doorbell,
  input  logic                  clr_sticky,
  output logic [NREQ-1:0]       overflow,
  output logic                  spurious_comp
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [IDW-1:0]             rr_q, rr_d;
  logic [IDW-1:0]             gnt_q, gnt_d;
  logic [TW-1:0]              to_cnt_q, to_cnt_d;
  logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]            ovf_q, ovf_d;
  logic                       spur_q, spur_d;
  logic [NREQ-1:0]            comp_q, comp_d;
  logic [NREQ-1:0]            tmo_q, tmo_d;
  logic                       submit_q, submit_d;
  logic                       busy_q, busy_d;

  logic                       any_pend;
  logic                       hi_found;
  logic [IDW-1:0]             hi_idx, lo_idx, sel;
  logic [NREQ-1:0]            sat_v, inc_v, dec_v;

  // Lowest nonzero index at or above rr wins; otherwise wrap to the lowest nonzero index.
  always_comb begin
    any_pend = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cnt_q[i] != '0) begin
        any_pend = 1'b1;
        lo_idx   = IDW'(i);
        if (i >= int'(rr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    sel = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    to_cnt_d = to_cnt_q;
    submit_d = 1'b0;
    comp_d   = '0;
    tmo_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (dev_ready && any_pend) begin
          gnt_d    = sel;
          rr_d     = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
          submit_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        to_cnt_d = to_cnt_q + TW'(1);
        // A completion landing on the timeout cycle is reported as a normal completion.
        if (dev_comp_doorbell) begin
          comp_d[gnt_q] = 1'b1;
          state_d       = S_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (int'(to_cnt_q) + 1 == TIMEOUT_CYCLES)) begin
          comp_d[gnt_q] = 1'b1;
          tmo_d[gnt_q]  = 1'b1;
          state_d       = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // A doorbell on a saturated counter is still absorbed when the same cycle retires one.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      sat_v[i] = (cnt_q[i] == '1);
      dec_v[i] = (state_q == S_DONE) && (gnt_q == IDW'(i)) && (cnt_q[i] != '0);
      inc_v[i] = req_doorbell[i] && (!sat_v[i] || dec_v[i]);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~{NREQ{clr_sticky}};
    for (int i = 0; i < NREQ; i++) begin
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_v[i] && !inc_v[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (req_doorbell[i] && sat_v[i] && !dec_v[i]) begin
        ovf_d[i] = 1'b1;
      end
    end
    spur_d = (spur_q && !clr_sticky) || (dev_comp_doorbell && (state_q != S_WAIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      gnt_q    <= '0;
      to_cnt_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= '0;
      spur_q   <= 1'b0;
      comp_q   <= '0;
      tmo_q    <= '0;
      submit_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      to_cnt_q <= to_cnt_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      spur_q   <= spur_d;
      comp_q   <= comp_d;
      tmo_q    <= tmo_d;
      submit_q <= submit_d;
      busy_q   <= busy_d;
    end
  end

  assign req_comp            = comp_q;
  assign req_timeout         = tmo_q;
  assign req_pending         = cnt_q;
  assign dev_submit_doorbell = submit_q;
  assign dev_grant_id        = gnt_q;
  assign dev_busy            = busy_q;
  assign overflow            = ovf_q;
  assign spurious_comp       = spur_q;

endmodule

// File: tb/tb_cai_doorbell_arbiter.sv
// Scoreboard bench for cai_doorbell_arbiter: NREQ=4, CNT_W=2, TIMEOUT_CYCLES=8.
module tb_cai_doorbell_arbiter;
  localparam int NREQ  = 4;
  localparam int CNT_W = 2;
  localparam int TO    = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_doorbell;
  logic [NREQ-1:0]       req_comp;
  logic [NREQ-1:0]       req_timeout;
  logic [NREQ*CNT_W-1:0] req_pending;
  logic                  dev_ready;
  logic                  dev_submit_doorbell;
  logic [1:0]            dev_grant_id;
  logic                  dev_busy;
  logic                  dev_comp_doorbell;
  logic                  clr_sticky;
  logic [NREQ-1:0]       overflow;
  logic                  spurious_comp;

  cai_doorbell_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_doorbell        (req_doorbell),
    .req_comp            (req_comp),
    .req_timeout         (req_timeout),
    .req_pending         (req_pending),
    .dev_ready           (dev_ready),
    .dev_submit_doorbell (dev_submit_doorbell),
    .dev_grant_id        (dev_grant_id),
    .dev_busy            (dev_busy),
    .dev_comp_doorbell   (dev_comp_doorbell),
    .clr_sticky          (clr_sticky),
    .overflow            (overflow),
    .spurious_comp       (spurious_comp)
  );

  always #5 clk = ~clk;

  // kind 0 = device submit, kind 1 = requester completion; delta = cycles after the submit
  typedef struct {
    int kind;
    int id;
    int to;
    int delta;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_sub = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int id, input int to, input int delta);
    exp_t e;
    e.kind = kind; e.id = id; e.to = to; e.delta = delta;
    q.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a submit or a completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (dev_submit_doorbell) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_submit: grant %0d at cycle %0d, none expected", dev_grant_id, cyc);
        end else begin
          e = q.pop_front();
          chk("submit_kind", 32'(0), 32'(e.kind));
          chk("submit_grant_id", 32'(dev_grant_id), 32'(e.id));
          chk("busy_at_submit", 32'(dev_busy), 32'(1));
        end
        last_sub = cyc;
      end
      if (req_comp != '0) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_comp: req_comp 0x%0h at cycle %0d, none expected", req_comp, cyc);
        end else begin
          e = q.pop_front();
          chk("comp_kind", 32'(1), 32'(e.kind));
          chk("comp_vector", 32'(req_comp), 32'(1 << e.id));
          chk("comp_timeout", 32'(req_timeout), e.to != 0 ? 32'(1 << e.id) : 32'(0));
          chk("comp_delay", 32'(cyc - last_sub), 32'(e.delta));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_submit(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (dev_submit_doorbell) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_submit: no dev_submit_doorbell within 30 cycles");
  endtask

  // Called in the ISSUE cycle; completion is sampled n cycles later, returns in DONE.
  task automatic complete(input int n);
    repeat (n) tick();
    dev_comp_doorbell = 1'b1;
    tick();
    dev_comp_doorbell = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_doorbell = '0;
    dev_comp_doorbell = 1'b0;
    clr_sticky = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic seen;
    rst_n = 1'b0;
    req_doorbell = '0;
    dev_ready = 1'b0;
    dev_comp_doorbell = 1'b0;
    clr_sticky = 1'b0;
    #2;
    chk("rst_req_comp", 32'(req_comp), 32'(0));
    chk("rst_req_timeout", 32'(req_timeout), 32'(0));
    chk("rst_pending", 32'(req_pending), 32'(0));
    chk("rst_submit", 32'(dev_submit_doorbell), 32'(0));
    chk("rst_busy", 32'(dev_busy), 32'(0));
    chk("rst_grant", 32'(dev_grant_id), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_spurious", 32'(spurious_comp), 32'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single submit to requester 2; completion lands on the timeout cycle and must win.
    dev_ready = 1'b1;
    expect_ev(0, 2, 0, 0);
    expect_ev(1, 2, 0, TO + 1);
    req_doorbell = 4'b0100;
    tick();
    req_doorbell = '0;
    chk("single_pending_after_db", 32'(req_pending), 32'h10);
    chk("single_idle_busy", 32'(dev_busy), 32'(0));
    wait_submit(n);
    chk("single_submit_latency", 32'(n), 32'(1));
    complete(TO);
    chk("single_pending_in_done", 32'(req_pending), 32'h10);
    tick();
    chk("single_pending_after", 32'(req_pending), 32'h00);
    chk("single_busy_after", 32'(dev_busy), 32'(0));

    // Round-robin: counts {0:2, 1:1, 3:1} drain in order 0,1,3,0.
    do_reset();
    dev_ready = 1'b0;
    req_doorbell = 4'b1011;
    tick();
    req_doorbell = 4'b0001;
    tick();
    req_doorbell = '0;
    chk("rr_preload", 32'(req_pending), 32'h46);
    expect_ev(0, 0, 0, 0); expect_ev(1, 0, 0, 2);
    expect_ev(0, 1, 0, 0); expect_ev(1, 1, 0, 2);
    expect_ev(0, 3, 0, 0); expect_ev(1, 3, 0, 2);
    expect_ev(0, 0, 0, 0); expect_ev(1, 0, 0, 2);
    dev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_submit(n);
      complete(1);
    end
    repeat (2) tick();
    chk("rr_drained", 32'(req_pending), 32'h00);

    // Doorbell for requester 0 during its own DONE keeps the count at 1.
    expect_ev(0, 0, 0, 0); expect_ev(1, 0, 0, 2);
    expect_ev(0, 0, 0, 0); expect_ev(1, 0, 0, 2);
    req_doorbell = 4'b0001;
    tick();
    req_doorbell = '0;
    wait_submit(n);
    tick();
    dev_comp_doorbell = 1'b1;
    tick();
    dev_comp_doorbell = 1'b0;
    req_doorbell = 4'b0001;
    chk("incdec_pending_in_done", 32'(req_pending), 32'h01);
    tick();
    req_doorbell = '0;
    chk("incdec_pending_after", 32'(req_pending), 32'h01);
    wait_submit(n);
    chk("incdec_second_latency", 32'(n), 32'(1));
    complete(1);
    tick();
    chk("incdec_drained", 32'(req_pending), 32'h00);

    // Saturation of requester 1 with the device not ready.
    dev_ready = 1'b0;
    req_doorbell = 4'b0010;
    repeat (3) tick();
    chk("sat_pending_3", 32'(req_pending), 32'h0C);
    chk("sat_no_overflow_yet", 32'(overflow), 32'(0));
    tick();
    req_doorbell = '0;
    chk("sat_pending_held", 32'(req_pending), 32'h0C);
    chk("sat_overflow_set", 32'(overflow), 32'b0010);
    clr_sticky = 1'b1;
    req_doorbell = 4'b0010;
    tick();
    req_doorbell = '0;
    chk("sat_set_beats_clear", 32'(overflow), 32'b0010);
    tick();
    clr_sticky = 1'b0;
    chk("sat_overflow_cleared", 32'(overflow), 32'(0));
    chk("sat_pending_after_clr", 32'(req_pending), 32'h0C);

    // Timeout on requester 3, then a late completion in IDLE.
    do_reset();
    dev_ready = 1'b1;
    expect_ev(0, 3, 0, 0);
    expect_ev(1, 3, 1, TO + 1);
    req_doorbell = 4'b1000;
    tick();
    req_doorbell = '0;
    wait_submit(n);
    repeat (TO + 2) tick();
    chk("to_idle_busy", 32'(dev_busy), 32'(0));
    chk("to_pending_after", 32'(req_pending), 32'h00);
    chk("to_no_spurious_yet", 32'(spurious_comp), 32'(0));
    dev_comp_doorbell = 1'b1;
    tick();
    dev_comp_doorbell = 1'b0;
    chk("to_spurious_set", 32'(spurious_comp), 32'(1));
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("to_spurious_cleared", 32'(spurious_comp), 32'(0));

    // Asynchronous reset while waiting on the device.
    do_reset();
    dev_ready = 1'b0;
    req_doorbell = 4'b0011;
    tick();
    req_doorbell = '0;
    chk("rstw_preload", 32'(req_pending), 32'h05);
    expect_ev(0, 0, 0, 0);
    dev_ready = 1'b1;
    wait_submit(n);
    repeat (2) tick();
    chk("rstw_busy_in_wait", 32'(dev_busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("rstw_pending", 32'(req_pending), 32'(0));
    chk("rstw_busy", 32'(dev_busy), 32'(0));
    chk("rstw_grant", 32'(dev_grant_id), 32'(0));
    chk("rstw_req_comp", 32'(req_comp), 32'(0));
    chk("rstw_submit", 32'(dev_submit_doorbell), 32'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | dev_submit_doorbell | (|req_comp);
    end
    chk("rstw_quiet_after_release", 32'(seen), 32'(0));
    expect_ev(0, 2, 0, 0);
    expect_ev(1, 2, 0, 2);
    req_doorbell = 4'b0100;
    tick();
    req_doorbell = '0;
    wait_submit(n);
    complete(1);
    repeat (2) tick();
    chk("scoreboard_empty", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cai_doorbell_arbiter.md
# cai_doorbell_arbiter

Round-robin scheduler that shares the single CAI accelerator device among NREQ host requesters. It keeps a pending-submission count per requester and forwards exactly one submit doorbell to the device at a time. It waits for the device completion doorbell, or a timeout, before returning a completion pulse to the owning requester. It sits between the CPU-side CAI doorbell sources and the device-side CAI submit/completion doorbells. `dev_grant_id` selects which requester's submit/completion ring base the device uses.

## Interface
- NREQ, 4: number of requesters, 2..16.
- CNT_W, 4: width of each pending counter; saturates at 2^CNT_W-1.
- TIMEOUT_CYCLES, 20000: WAIT-state limit in cycles; 0 disables the timeout.
- IDW, $clog2(NREQ): grant index width (derived).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_doorbell  in  NREQ  per-requester submit pulse; each high cycle adds one pending command.
- req_comp  out  NREQ  one-cycle completion pulse to the owning requester.
- req_timeout  out  NREQ  asserted with req_comp when the completion was caused by a timeout.
- req_pending  out  NREQ*CNT_W  pending counts, requester i at [i*CNT_W +: CNT_W].
- dev_ready  in  1  device ready (CAI status bit 0).
- dev_submit_doorbell  out  1  one-cycle submit pulse to the device.
- dev_grant_id  out  IDW  requester currently owning the device; valid while dev_busy.
- dev_busy  out  1  high in ISSUE, WAIT and DONE.
- dev_comp_doorbell  in  1  device completion pulse.
- clr_sticky  in  1  clears overflow and spurious_comp.
- overflow  out  NREQ  sticky; a doorbell arrived while that requester's counter was saturated.
- spurious_comp  out  1  sticky; dev_comp_doorbell seen outside WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- Round-robin pointer rr: reset value 0.
- IDLE:
  - If dev_ready=1 and any counter is nonzero, choose g = the first nonzero index searching upward from rr, with wrap.
  - Latch dev_grant_id=g, set rr=(g+1) mod NREQ, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: dev_submit_doorbell=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - The timeout counter increments every cycle.
  - If dev_comp_doorbell=1, go to DONE with to_flag=0.
  - Else, if TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES, go to DONE with to_flag=1.
  - If completion and timeout occur in the same cycle, the completion wins (to_flag=0).
- DONE:
  - req_comp[g]=1 and req_timeout[g]=to_flag for this cycle.
  - Decrement counter g, clamped at 0.
  - Go to IDLE.
- Pending counter update each cycle is +inc −dec:
  - inc = req_doorbell[i] and the counter is not saturated.
  - dec = DONE and g==i.
  - Doorbell and decrement on the same cycle leave the counter unchanged.
- Doorbell while saturated (and no decrement that cycle): counter holds and overflow[i] sets.
- dev_comp_doorbell in IDLE, ISSUE or DONE: ignored for sequencing; spurious_comp sets.
- clr_sticky clears overflow and spurious_comp. If a set condition occurs in the same cycle, the set wins.
- dev_ready is sampled only in IDLE. Dropping it during WAIT does not abort the command.
- dev_grant_id holds its value from ISSUE through DONE and keeps the last grant while in IDLE.

## Timing
- Reset values, asserted asynchronously:
  - All outputs 0.
  - All counters 0, rr=0, state IDLE, timeout counter 0.
- Doorbell at cycle 0 (idle arbiter, dev_ready=1):
  - Counter=1 after edge 0.
  - IDLE grants in cycle 1.
  - dev_submit_doorbell high in cycle 2.
- Completion sampled in WAIT at cycle k: req_comp is high in cycle k+1, then IDLE in cycle k+2.
- Minimum back-to-back spacing of device submits: 4 cycles plus device latency.
- Timeout: with no completion, DONE occurs TIMEOUT_CYCLES+1 cycles after the ISSUE cycle.
- Outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Single submit, NREQ=4, dev_ready=1:
  - Pulse req_doorbell[2].
  - Expect one dev_submit_doorbell with dev_grant_id=2.
  - Drive dev_comp_doorbell 10 cycles later.
  - Expect req_comp[2] on the next cycle, req_timeout=0, pending[2] returning 1→0.
- Round-robin fairness:
  - Preload counts {0:2, 1:1, 3:1} via doorbells.
  - Complete every command immediately.
  - Expect grant order 0,1,3,0 and all counters 0 at the end.
- Simultaneous increment and decrement:
  - Pulse req_doorbell[0] in the same cycle as DONE for requester 0 with count 1.
  - Expect count to stay 1 and a second submit to follow.
- Saturation, CNT_W=2:
  - Issue 4 doorbells to requester 1 with dev_ready=0.
  - Expect pending[1]=3 and overflow[1]=1.
  - clr_sticky clears overflow[1]; count remains 3.
- Timeout, TIMEOUT_CYCLES=8:
  - Submit to requester 3 and never complete.
  - Expect req_comp[3]=req_timeout[3]=1 exactly 9 cycles after dev_submit_doorbell.
  - A late dev_comp_doorbell in IDLE sets spurious_comp.
- Reset mid-WAIT:
  - Deassert rst_n while in WAIT with pending {1,1,0,0}.
  - Expect all outputs and counters at 0 immediately.
  - No req_comp pulse and no dev_submit_doorbell until a new doorbell arrives after reset release.
